// File: rtl/maxpool_multi.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_multi
// Brief    : CH-lane windowed pooling unit (max / rounded average / bypass).
// Revision : 1.0 - initial release
// ============================================================================
module maxpool_multi #(
    parameter int DATA_W = 8,
    parameter int CH     = 4,
    parameter int WIN    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CH*DATA_W-1:0] in,
    input  logic                 in_valid,
    input  logic [1:0]           mode,
    input  logic                 flush,
    output logic [CH*DATA_W-1:0] out,
    output logic                 out_valid,
    output logic                 busy
);

    localparam int LOG2W = $clog2(WIN);
    localparam int SUM_W = DATA_W + LOG2W + 1;

    localparam logic [1:0]             c_MODE_BYPASS = 2'b00;
    localparam logic [1:0]             c_MODE_MAX    = 2'b01;
    localparam logic [1:0]             c_MODE_AVG    = 2'b10;
    localparam logic [LOG2W-1:0]       c_LAST        = LOG2W'(WIN - 1);
    localparam logic signed [SUM_W-1:0] c_HALF       = SUM_W'(WIN / 2);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [LOG2W-1:0] r_count;
    logic [1:0]       r_mode;
    logic             r_valid;

    logic       w_first;
    logic [1:0] w_mode;
    logic       w_bypass;
    logic       w_avg;
    logic       w_accept;
    logic       w_last;
    logic       w_emit;

    // Mode is taken live on a window's first sample and held thereafter.
    assign w_first  = (r_state == ST_IDLE);
    assign w_mode   = w_first ? mode : r_mode;
    assign w_bypass = (w_mode == c_MODE_BYPASS);
    assign w_avg    = (w_mode == c_MODE_AVG);
    assign w_accept = in_valid & ~flush;
    assign w_last   = w_accept & ~w_bypass & (r_count == c_LAST);
    assign w_emit   = w_accept & (w_bypass | w_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && !w_bypass) w_state_next = ST_ACC;
            ST_ACC:  if (flush || w_last)       w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_mode  <= c_MODE_MAX;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_emit;
            if (flush) begin
                r_count <= '0;
            end else if (w_accept && !w_bypass) begin
                r_count <= w_last ? '0 : r_count + LOG2W'(1);
            end
            if (w_accept && w_first) begin
                r_mode <= mode;
            end
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_lane
        logic signed [DATA_W-1:0] w_smp;
        logic signed [DATA_W-1:0] w_max_next;
        logic signed [DATA_W-1:0] w_res_next;
        logic signed [DATA_W-1:0] r_max;
        logic signed [DATA_W-1:0] r_res;
        logic signed [SUM_W-1:0]  w_ext;
        logic signed [SUM_W-1:0]  w_sum_next;
        logic signed [SUM_W-1:0]  w_rnd;
        logic signed [SUM_W-1:0]  r_sum;
        logic                     w_unused_bits;

        assign w_smp      = in[k*DATA_W +: DATA_W];
        assign w_ext      = {{(SUM_W-DATA_W){w_smp[DATA_W-1]}}, w_smp};
        assign w_max_next = (w_first || (w_smp > r_max)) ? w_smp : r_max;
        assign w_sum_next = w_first ? w_ext : (r_sum + w_ext);
        // Taking the slice above LOG2W is the arithmetic shift; the top bit is pure headroom.
        assign w_rnd      = w_sum_next + c_HALF;
        assign w_res_next = w_bypass ? w_smp :
                            (w_avg ? w_rnd[LOG2W +: DATA_W] : w_max_next);
        assign w_unused_bits = ^{w_rnd[SUM_W-1], w_rnd[LOG2W-1:0]};

        always_ff @(posedge clk) begin
            if (reset) begin
                r_max <= '0;
                r_sum <= '0;
                r_res <= '0;
            end else begin
                if (flush) begin
                    r_max <= '0;
                    r_sum <= '0;
                end else if (w_accept && !w_bypass) begin
                    r_max <= w_max_next;
                    r_sum <= w_sum_next;
                end
                if (w_emit) begin
                    r_res <= w_res_next;
                end
            end
        end

        assign out[k*DATA_W +: DATA_W] = r_res;
    end

    assign out_valid = r_valid;
    assign busy      = (r_state == ST_ACC);

endmodule
`default_nettype wire

// File: tb/tb_maxpool_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxpool_multi
// Brief    : Directed self-checking bench for maxpool_multi (CH=2, WIN=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_maxpool_multi;

    localparam int DATA_W = 8;
    localparam int CH     = 2;
    localparam int WIN    = 4;

    localparam logic [1:0] c_BYP = 2'b00;
    localparam logic [1:0] c_MAX = 2'b01;
    localparam logic [1:0] c_AVG = 2'b10;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [CH*DATA_W-1:0] in = '0;
    logic                 in_valid = 1'b0;
    logic [1:0]           mode = c_MAX;
    logic                 flush = 1'b0;
    logic [CH*DATA_W-1:0] out;
    logic                 out_valid;
    logic                 busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulse = 0;

    maxpool_multi #(.DATA_W(DATA_W), .CH(CH), .WIN(WIN)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .in_valid (in_valid),
        .mode     (mode),
        .flush    (flush),
        .out      (out),
        .out_valid(out_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lane(input int k);
        logic signed [DATA_W-1:0] v;
        v = out[k*DATA_W +: DATA_W];
        return int'(v);
    endfunction

    // One clock cycle of stimulus; outputs are observed 1 time unit after the edge.
    task automatic step(input int l0, input int l1, input logic v,
                        input logic [1:0] m, input logic f);
        in       = {DATA_W'(l1), DATA_W'(l0)};
        in_valid = v;
        mode     = m;
        flush    = f;
        @(posedge clk);
        #1;
        if (out_valid) n_pulse++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, c_MAX, 1'b0);
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset(2);
        chk("rst_out",   int'(out),       0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy",  int'(busy),      0);

        // Max window, including the most negative value
        n_pulse = 0;
        step(3, -128, 1'b1, c_MAX, 1'b0);
        chk("max_busy_rise", int'(busy), 1);
        step(-5, -128, 1'b1, c_MAX, 1'b0);
        step(7, -128, 1'b1, c_MAX, 1'b0);
        chk("max_no_early", int'(out_valid), 0);
        step(2, -128, 1'b1, c_MAX, 1'b0);
        chk("max_valid", int'(out_valid), 1);
        chk("max_l0", lane(0), 7);
        chk("max_l1", lane(1), -128);
        chk("max_busy_fall", int'(busy), 0);
        idle(1);
        chk("max_pulse_len", int'(out_valid), 0);
        chk("max_hold", lane(0), 7);
        chk("max_npulse", n_pulse, 1);

        // Average windows with rounding
        step(1, -1, 1'b1, c_AVG, 1'b0);
        step(2, -2, 1'b1, c_AVG, 1'b0);
        step(3, -3, 1'b1, c_AVG, 1'b0);
        step(4, -4, 1'b1, c_AVG, 1'b0);
        chk("avg_valid", int'(out_valid), 1);
        chk("avg_l0", lane(0), 3);
        chk("avg_l1", lane(1), -2);
        for (int i = 0; i < WIN; i++) step(127, -128, 1'b1, c_AVG, 1'b0);
        chk("avg_pos_ext", lane(0), 127);
        chk("avg_neg_ext", lane(1), -128);
        for (int i = 0; i < WIN; i++) step((i == 3) ? 2 : 0, (i == 3) ? -2 : 0, 1'b1, c_AVG, 1'b0);
        chk("avg_half_pos", lane(0), 1);
        chk("avg_half_neg", lane(1), 0);

        // Bypass
        step(127, -128, 1'b1, c_BYP, 1'b0);
        chk("byp_valid", int'(out_valid), 1);
        chk("byp_l0", lane(0), 127);
        chk("byp_l1", lane(1), -128);
        chk("byp_busy", int'(busy), 0);
        step(5, -6, 1'b1, c_BYP, 1'b0);
        chk("byp_valid2", int'(out_valid), 1);
        chk("byp_l0_2", lane(0), 5);
        chk("byp_busy2", int'(busy), 0);
        idle(1);
        chk("byp_drop", int'(out_valid), 0);

        // Gapped window followed by a back-to-back window
        n_pulse = 0;
        step(1, -1, 1'b1, c_MAX, 1'b0); idle(2);
        step(9, -9, 1'b1, c_MAX, 1'b0); idle(2);
        step(4, -4, 1'b1, c_MAX, 1'b0); idle(2);
        chk("gap_busy", int'(busy), 1);
        step(6, -6, 1'b1, c_MAX, 1'b0);
        chk("gap_l0", lane(0), 9);
        chk("gap_l1", lane(1), -1);
        for (int i = 0; i < WIN; i++) step(5, 5, 1'b1, c_MAX, 1'b0);
        chk("b2b_l0", lane(0), 5);
        chk("b2b_npulse", n_pulse, 2);

        // Flush with a simultaneous sample, then a mid-window mode change
        n_pulse = 0;
        step(50, 50, 1'b1, c_MAX, 1'b0);
        step(60, 60, 1'b1, c_MAX, 1'b0);
        step(99, 99, 1'b1, c_MAX, 1'b1);
        chk("flush_valid", int'(out_valid), 0);
        chk("flush_busy", int'(busy), 0);
        idle(2);
        step(1, 10, 1'b1, c_MAX, 1'b0);
        step(2, -20, 1'b1, c_AVG, 1'b0);
        step(3, 30, 1'b1, c_AVG, 1'b0);
        step(4, -40, 1'b1, c_AVG, 1'b0);
        chk("latch_l0", lane(0), 4);
        chk("latch_l1", lane(1), 30);
        chk("flush_npulse", n_pulse, 1);

        // Reset in the middle of a window
        n_pulse = 0;
        for (int i = 0; i < 3; i++) step(100, 100, 1'b1, c_MAX, 1'b0);
        do_reset(1);
        chk("mrst_out", int'(out), 0);
        chk("mrst_valid", int'(out_valid), 0);
        chk("mrst_busy", int'(busy), 0);
        for (int i = 0; i < WIN; i++) step(7, 7, 1'b1, c_MAX, 1'b0);
        idle(2);
        chk("mrst_npulse", n_pulse, 1);
        chk("mrst_l0", lane(0), 7);
        chk("mrst_l1", lane(1), 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
